// File: rtl/ser_pkg.sv
// Shared types and helpers for the framed bit serializer.
package ser_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } ser_state_t;

    // Widest payload next_bit can index; DATA_W must not exceed this.
    localparam int MAX_W = 64;

    // Bit of the shift word sent in data slot idx (0 = first data bit on the line).
    function automatic logic next_bit(input logic [MAX_W-1:0] shift,
                                      input int               idx,
                                      input int               data_w,
                                      input logic             lsb_first);
        logic [5:0] pos;
        pos = lsb_first ? 6'(idx) : 6'(data_w - 1 - idx);
        return shift[pos];
    endfunction

endpackage

// File: rtl/ser_hold_buf.sv
// One-deep word buffer in front of the serializer.
// Handshake: a word transfers on a rising edge where s_valid & s_ready are both 1;
// s_data must be stable while s_valid is high, and s_ready never depends on s_valid.
module ser_hold_buf #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              pop,
    output logic              full,
    output logic [DATA_W-1:0] dout
);

    // A full buffer is never ready, so a pop and an accept can never share a cycle.
    assign s_ready = ~full & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            full <= 1'b0;
            dout <= '0;
        end else if (pop) begin
            full <= 1'b0;
        end else if (s_valid && s_ready) begin
            full <= 1'b1;
            dout <= s_data;
        end
    end

endmodule

// File: rtl/bit_serializer.sv
// Packs buffered parallel words into start/data/stop frames on a registered
// serial line, advancing one bit per bit_en strobe. state is a debug view of the FSM.
module bit_serializer
    import ser_pkg::*;
#(
    parameter int   DATA_W     = 8,
    parameter int   LSB_FIRST  = 1,
    parameter logic IDLE_LEVEL = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              bit_en,
    output logic              ser_out,
    output logic              busy,
    output logic              done,
    output ser_state_t        state
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
    localparam logic LSB = (LSB_FIRST != 0);

    logic              hold_full;
    logic [DATA_W-1:0] hold_data;
    logic [DATA_W-1:0] shift;
    logic [CNT_W-1:0]  cnt;
    logic              pop;

    // The hold word is consumed only where a new frame can begin.
    assign pop  = bit_en & hold_full & ((state == ST_IDLE) | (state == ST_STOP));
    assign busy = (state != ST_IDLE);

    ser_hold_buf #(
        .DATA_W(DATA_W)
    ) u_hold (
        .clk    (clk),
        .rst    (rst),
        .s_valid(s_valid),
        .s_ready(s_ready),
        .s_data (s_data),
        .pop    (pop),
        .full   (hold_full),
        .dout   (hold_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            shift   <= '0;
            cnt     <= '0;
            ser_out <= IDLE_LEVEL;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (bit_en) begin
                case (state)
                    ST_IDLE: begin
                        if (hold_full) begin
                            state   <= ST_START;
                            shift   <= hold_data;
                            ser_out <= ~IDLE_LEVEL;
                        end
                    end
                    ST_START: begin
                        state   <= ST_DATA;
                        cnt     <= '0;
                        ser_out <= next_bit(MAX_W'(shift), 0, DATA_W, LSB);
                    end
                    ST_DATA: begin
                        if (cnt == CNT_LAST) begin
                            state   <= ST_STOP;
                            ser_out <= IDLE_LEVEL;
                        end else begin
                            cnt     <= cnt + CNT_W'(1);
                            ser_out <= next_bit(MAX_W'(shift), int'(cnt) + 1, DATA_W, LSB);
                        end
                    end
                    ST_STOP: begin
                        done <= 1'b1;
                        // A waiting word starts straight after the stop bit, no idle gap.
                        if (hold_full) begin
                            state   <= ST_START;
                            shift   <= hold_data;
                            ser_out <= ~IDLE_LEVEL;
                        end else begin
                            state   <= ST_IDLE;
                            ser_out <= IDLE_LEVEL;
                        end
                    end
                    default: begin
                        state   <= ST_IDLE;
                        ser_out <= IDLE_LEVEL;
                    end
                endcase
            end
        end
    end

endmodule
